video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates raster timing for the DVI output stage: HSync, VSync and VideoEnable on the pixel clock, plus the current pixel coordinates.
- Issues a per-line fetch request to the SDRAM line-buffer filler one line ahead of display.
- Flags underruns when a fetch is not acknowledged in time.
- Sits directly upstream of the TMDS encoder/serializer output block and shares its PixelClk domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HSync active level
VS_POL, 0, VSync active level

Ports:
PixelClk  in  1  pixel clock; all logic on rising edge
nReset  in  1  asynchronous, active-low reset
HSync  out  1  horizontal sync, active level HS_POL
VSync  out  1  vertical sync, active level VS_POL
VideoEnable  out  1  high during visible pixels
PixelX  out  12  horizontal position of current output cycle
PixelY  out  12  vertical position of current output cycle
FrameStart  out  1  one-cycle pulse at output position (0,0)
LineReq  out  1  request to fetch line LineNum into the line buffer
LineNum  out  12  line index being requested; stable while LineReq high
LineAck  in  1  fetch accepted; sampled only while LineReq high
Underrun  out  1  sticky: a request went unacknowledged

Behaviour:
- Interface decision: one clock (PixelClk); reset is asynchronous and active-low (nReset).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4096.
- Internal position counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1.
  - h increments every cycle. At H_TOTAL-1, h wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1.
- All outputs are registered decodes of the counter position, so every output lags the counters by exactly one cycle and all outputs are mutually consistent.
- Decodes for a position (h, v):
  - VideoEnable = (h < H_ACTIVE) and (v < V_ACTIVE).
  - HSync = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - VSync = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for the whole line; otherwise ~VS_POL.
  - PixelX = h, PixelY = v.
  - FrameStart = 1 when h = 0 and v = 0.
- Reset (nReset low, asynchronous):
  - Counters = 0; PixelX = PixelY = 0; LineNum = 0.
  - VideoEnable = 0, FrameStart = 0, LineReq = 0, Underrun = 0.
  - HSync = ~HS_POL, VSync = ~VS_POL.
- First rising edge after reset release: outputs present position (0,0), so VideoEnable = 1 and FrameStart = 1; counters advance to (1,0).
- Reset asserted mid-frame aborts any pending request and clears Underrun.
- Line fetch handshake:
  - Let n = (v+1) mod V_TOTAL. On the output cycle for position h = H_ACTIVE of line v: if n < V_ACTIVE, LineReq rises and LineNum = n.
  - The request for line 0 is therefore issued on line V_TOTAL-1.
  - No request is issued on lines V_ACTIVE-1 .. V_TOTAL-2.
  - LineReq stays high until LineAck = 1 is sampled; LineReq falls on the following edge. LineAck while LineReq is low is ignored.
  - Deadline: the output cycle for h = H_TOTAL-1 on the same line. Ack sampled in that cycle counts as success.
  - No ack by the deadline: LineReq drops on the next edge and Underrun is set. Underrun stays set until reset.
  - Only one request is outstanding at a time, and LineNum never changes while LineReq is high.
- Counter arithmetic is unsigned 12-bit. Parameters are static; no runtime mode change.

Test Plan:
- Reset release with default parameters:
  - After edge 1: VideoEnable=1, PixelX=0, PixelY=0, FrameStart=1, HSync=1, VSync=1.
  - After edge 2: FrameStart=0, PixelX=1.
- Horizontal timing over one line:
  - VideoEnable high for PixelX 0..639.
  - HSync low exactly for PixelX 656..751 (96 cycles).
  - Line period 800 cycles.
- Vertical timing over one frame:
  - VSync low for PixelY 490..491 (1600 cycles).
  - VideoEnable never high for PixelY ≥ 480.
  - FrameStart pulses every 420000 cycles.
- Requests with LineAck tied high one cycle after LineReq:
  - Request at PixelX=640 on PixelY=0 with LineNum=1; each request is 2 cycles high.
  - PixelY=524 yields LineNum=0.
  - No request on PixelY 479..523.
  - Underrun stays 0.
- Late and missing ack:
  - Ack at PixelX=799 → success, Underrun=0.
  - No ack on line 5 → LineReq falls after PixelX=799 and Underrun=1.
  - The next line's request still issues normally.
- nReset pulsed low mid-line at PixelY=100 while LineReq is high:
  - All outputs immediately take reset values.
  - Timing restarts at (0,0).

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI output path: sync/enable decodes, pixel coordinates,
// and a one-line-ahead fetch handshake toward the SDRAM line-buffer filler.
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        PixelClk,
    input  logic        nReset,
    output logic        HSync,
    output logic        VSync,
    output logic        VideoEnable,
    output logic [11:0] PixelX,
    output logic [11:0] PixelY,
    output logic        FrameStart,
    output logic        LineReq,
    output logic [11:0] LineNum,
    input  logic        LineAck,
    output logic        Underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] REQ_H    = 12'(H_ACTIVE);
    // 13-bit bounds so a window ending exactly at 4096 still compares correctly
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEGIN = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEGIN = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hCount_r;
    logic [11:0] vCount_r;
    logic [11:0] hNext_s;
    logic [11:0] vNext_s;
    logic [11:0] nextLine_s;
    logic        videoEn_s;
    logic        hSync_s;
    logic        vSync_s;
    logic        frameStart_s;
    logic        reqStart_s;
    logic        deadline_s;

    // Line that follows the current one, wrapping at the end of the frame
    always_comb begin
        nextLine_s = vCount_r + 12'd1;
        if (vCount_r == V_LAST) begin
            nextLine_s = 12'd0;
        end else begin
            nextLine_s = vCount_r + 12'd1;
        end
    end

    // Next raster position
    always_comb begin
        hNext_s = hCount_r + 12'd1;
        vNext_s = vCount_r;
        if (hCount_r == H_LAST) begin
            hNext_s = 12'd0;
            vNext_s = nextLine_s;
        end else begin
            hNext_s = hCount_r + 12'd1;
            vNext_s = vCount_r;
        end
    end

    // Position decodes that feed the output registers
    always_comb begin
        videoEn_s    = ({1'b0, hCount_r} < H_ACT) && ({1'b0, vCount_r} < V_ACT);
        hSync_s      = (({1'b0, hCount_r} >= HS_BEGIN) && ({1'b0, hCount_r} < HS_END)) ? HS_POL : ~HS_POL;
        vSync_s      = (({1'b0, vCount_r} >= VS_BEGIN) && ({1'b0, vCount_r} < VS_END)) ? VS_POL : ~VS_POL;
        frameStart_s = (hCount_r == 12'd0) && (vCount_r == 12'd0);
        // Fetch for the next line is launched as the current line leaves the active region
        reqStart_s   = (hCount_r == REQ_H) && ({1'b0, nextLine_s} < V_ACT);
        // PixelX shows the last pixel of the line: the final cycle an ack can land
        deadline_s   = (PixelX == H_LAST);
    end

    // Raster position counters
    always_ff @(posedge PixelClk or negedge nReset) begin
        if (!nReset) begin
            hCount_r <= 12'd0;
            vCount_r <= 12'd0;
        end else begin
            hCount_r <= hNext_s;
            vCount_r <= vNext_s;
        end
    end

    // Registered timing outputs, one cycle behind the counters
    always_ff @(posedge PixelClk or negedge nReset) begin
        if (!nReset) begin
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            VideoEnable <= 1'b0;
            FrameStart  <= 1'b0;
            PixelX      <= 12'd0;
            PixelY      <= 12'd0;
        end else begin
            HSync       <= hSync_s;
            VSync       <= vSync_s;
            VideoEnable <= videoEn_s;
            FrameStart  <= frameStart_s;
            PixelX      <= hCount_r;
            PixelY      <= vCount_r;
        end
    end

    // Fetch request handshake and sticky underrun flag
    always_ff @(posedge PixelClk or negedge nReset) begin
        if (!nReset) begin
            LineReq  <= 1'b0;
            LineNum  <= 12'd0;
            Underrun <= 1'b0;
        end else if (reqStart_s) begin
            LineReq  <= 1'b1;
            LineNum  <= nextLine_s;
            Underrun <= Underrun;
        end else if (LineReq && LineAck) begin
            LineReq  <= 1'b0;
            LineNum  <= LineNum;
            Underrun <= Underrun;
        end else if (LineReq && deadline_s) begin
            LineReq  <= 1'b0;
            LineNum  <= LineNum;
            Underrun <= 1'b1;
        end else begin
            LineReq  <= LineReq;
            LineNum  <= LineNum;
            Underrun <= Underrun;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default horizontal timing with a shortened frame height,
// a per-cycle position-based reference model, plus hand-computed directed checks.
module tb_video_timing_gen;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int HT = HA + HF + HS + HB;
    // Frame height reduced so several frames fit a short run; horizontal timing is the default
    localparam int VA = 20;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 4;
    localparam int VT = VA + VF + VS + VB;

    logic        PixelClk = 1'b0;
    logic        nReset;
    logic        HSync;
    logic        VSync;
    logic        VideoEnable;
    logic [11:0] PixelX;
    logic [11:0] PixelY;
    logic        FrameStart;
    logic        LineReq;
    logic [11:0] LineNum;
    logic        LineAck;
    logic        Underrun;

    int nTests = 0;
    int nFails = 0;
    int ackMode = 0;   // 0: ack one cycle after request, 1: ack only at PixelX=HT-1, 2: never

    // model state: output position currently shown and handshake status
    bit mValid = 1'b0;
    int mx = 0;
    int my = 0;
    bit mReq = 1'b0;
    bit mUnd = 1'b0;
    int mNum = 0;
    bit prevReq = 1'b0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .PixelClk(PixelClk), .nReset(nReset), .HSync(HSync), .VSync(VSync),
        .VideoEnable(VideoEnable), .PixelX(PixelX), .PixelY(PixelY),
        .FrameStart(FrameStart), .LineReq(LineReq), .LineNum(LineNum),
        .LineAck(LineAck), .Underrun(Underrun)
    );

    always #5 PixelClk = ~PixelClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model and per-cycle compare; also plays the line-buffer filler on LineAck
    initial begin
        logic [41:0] expV;
        logic [41:0] actV;
        logic eHs, eVs, eVe, eFs;
        LineAck = 1'b0;
        forever begin
            @(posedge PixelClk);
            #1;
            if (!nReset) begin
                mValid = 1'b0; mReq = 1'b0; mUnd = 1'b0; mNum = 0;
            end else if (!mValid) begin
                mValid = 1'b1; mx = 0; my = 0;
            end else begin
                if (mReq && LineAck) mReq = 1'b0;
                else if (mReq && mx == HT - 1) begin mReq = 1'b0; mUnd = 1'b1; end
                mx = mx + 1;
                if (mx == HT) begin mx = 0; my = (my + 1) % VT; end
                if (mx == HA && ((my + 1) % VT) < VA) begin mReq = 1'b1; mNum = (my + 1) % VT; end
            end
            eVe = mValid && mx < HA && my < VA;
            eHs = !(mValid && mx >= HA + HF && mx < HA + HF + HS);
            eVs = !(mValid && my >= VA + VF && my < VA + VF + VS);
            eFs = mValid && mx == 0 && my == 0;
            expV = {eHs, eVs, eVe, eFs, mReq, mUnd, 12'(mValid ? mx : 0), 12'(mValid ? my : 0),
                    12'(mReq ? mNum : 0)};
            actV = {HSync, VSync, VideoEnable, FrameStart, LineReq, Underrun, PixelX, PixelY,
                    (LineReq ? LineNum : 12'd0)};
            nTests++;
            if (actV !== expV) begin
                nFails++;
                $display("FAIL model_cycle at t=%0t: got %h, expected %h", $time, actV, expV);
            end
            case (ackMode)
                0:       LineAck = LineReq && prevReq;
                1:       LineAck = (PixelX == 12'(HT - 1));
                default: LineAck = 1'b0;
            endcase
            if (!nReset) LineAck = 1'b0;
            prevReq = LineReq;
        end
    end

    task automatic step();
        @(posedge PixelClk);
        #2;
    endtask

    initial begin
        int veCnt, hsLow, hsFirst, reqX, reqNum, reqLen;
        int cyc, vsLow, vsFirst, veLate, reqRises, badReq, num0, und, reqHigh;
        bit done, pReq;
        nReset = 1'b0;
        ackMode = 0;
        repeat (3) step();
        check("rst_hsync", HSync, 1);
        check("rst_vsync", VSync, 1);
        check("rst_ve", VideoEnable, 0);
        check("rst_fs", FrameStart, 0);
        check("rst_req", LineReq, 0);
        check("rst_und", Underrun, 0);
        check("rst_x", PixelX, 0);
        check("rst_y", PixelY, 0);
        check("rst_linenum", LineNum, 0);
        @(negedge PixelClk);
        nReset = 1'b1;

        step();
        check("e1_ve", VideoEnable, 1);
        check("e1_x", PixelX, 0);
        check("e1_y", PixelY, 0);
        check("e1_fs", FrameStart, 1);
        check("e1_hsync", HSync, 1);
        check("e1_vsync", VSync, 1);
        step();
        check("e2_fs", FrameStart, 0);
        check("e2_x", PixelX, 1);

        // remainder of line 0
        veCnt = 2; hsLow = 0; hsFirst = -1; reqX = -1; reqNum = -1; reqLen = 0;
        repeat (HT - 2) begin
            step();
            if (VideoEnable) veCnt++;
            if (!HSync) begin
                if (hsFirst < 0) hsFirst = int'(PixelX);
                hsLow++;
            end
            if (LineReq) begin
                if (reqX < 0) begin reqX = int'(PixelX); reqNum = int'(LineNum); end
                reqLen++;
            end
        end
        check("line_ve_count", veCnt, 640);
        check("line_hsync_low", hsLow, 96);
        check("line_hsync_first", hsFirst, 656);
        check("req0_x", reqX, 640);
        check("req0_linenum", reqNum, 1);
        check("req0_len", reqLen, 2);
        step();
        check("line_period_x", PixelX, 0);
        check("line_period_y", PixelY, 1);

        // rest of the first frame with prompt acks
        cyc = HT; vsLow = 0; vsFirst = -1; veLate = 0; reqRises = 0; badReq = 0;
        num0 = -1; und = 0; done = 1'b0; pReq = LineReq;
        for (int i = 0; i < 30000 && !done; i++) begin
            step();
            cyc++;
            if (FrameStart) done = 1'b1;
            else begin
                if (!VSync) begin
                    if (vsFirst < 0) vsFirst = int'(PixelY);
                    vsLow++;
                end
                if (VideoEnable && PixelY >= 12'(VA)) veLate++;
                if (LineReq && !pReq) begin
                    reqRises++;
                    if (PixelY >= 12'(VA - 1) && PixelY <= 12'(VT - 2)) badReq++;
                    if (PixelY == 12'(VT - 1)) num0 = int'(LineNum);
                end
                pReq = LineReq;
                if (Underrun) und++;
            end
        end
        check("frame_reached", done, 1);
        check("frame_period", cyc, 23200);
        check("vsync_low_cycles", vsLow, 1600);
        check("vsync_first_line", vsFirst, 23);
        check("ve_below_active", veLate, 0);
        check("frame_req_count", reqRises, 19);
        check("no_req_blank", badReq, 0);
        check("req_last_line_num", num0, 0);
        check("auto_underrun", und, 0);

        // lines 0..4: ack only on the last pixel of the line
        ackMode = 1;
        reqHigh = 0;
        repeat (5 * HT) begin
            step();
            if (LineReq) reqHigh++;
        end
        check("late_pos_y", PixelY, 5);
        check("late_req_high", reqHigh, 5 * 160);
        check("late_underrun", Underrun, 0);

        // line 5: no ack at all
        ackMode = 2;
        repeat (HT - 1) step();
        check("miss_x", PixelX, 799);
        check("miss_req_at_deadline", LineReq, 1);
        check("miss_und_before", Underrun, 0);
        step();
        check("miss_req_dropped", LineReq, 0);
        check("miss_underrun", Underrun, 1);
        check("miss_next_y", PixelY, 6);

        // line 6: normal handshake resumes
        ackMode = 0;
        repeat (HA) step();
        check("resume_req", LineReq, 1);
        check("resume_linenum", LineNum, 7);
        step();
        check("resume_req_2nd", LineReq, 1);
        step();
        check("resume_req_done", LineReq, 0);
        check("resume_und_sticky", Underrun, 1);

        // async reset mid-line while a request is pending
        ackMode = 2;
        repeat (4 * HT + 700 - 642) step();
        check("prerst_y", PixelY, 10);
        check("prerst_x", PixelX, 700);
        check("prerst_req", LineReq, 1);
        #3;
        nReset = 1'b0;
        #1;
        check("arst_req", LineReq, 0);
        check("arst_und", Underrun, 0);
        check("arst_ve", VideoEnable, 0);
        check("arst_x", PixelX, 0);
        check("arst_y", PixelY, 0);
        check("arst_hsync", HSync, 1);
        check("arst_vsync", VSync, 1);
        check("arst_linenum", LineNum, 0);
        repeat (2) step();
        @(negedge PixelClk);
        nReset = 1'b1;
        ackMode = 0;
        step();
        check("restart_fs", FrameStart, 1);
        check("restart_x", PixelX, 0);
        check("restart_y", PixelY, 0);
        check("restart_ve", VideoEnable, 1);
        repeat (3 * HT) step();
        check("restart_y3", PixelY, 3);
        check("restart_und", Underrun, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
